// File: rtl/spi_gate_master_if.sv
// Handshake and SPI pins of spi_gate_master, grouped for port connection.
interface spi_gate_master_if;
   logic       start;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       busy;
   logic       done;
   logic [7:0] rdata;
   logic       SCLK;
   logic       CSB;
   logic       MOSI;
   logic       MISO;

   modport master (
      input  start, addr, wdata, MISO,
      output busy, done, rdata, SCLK, CSB, MOSI
   );

   modport slave (
      output start, addr, wdata, MISO,
      input  busy, done, rdata, SCLK, CSB, MOSI
   );
endinterface

// File: rtl/spi_gate_master.sv
// SPI master issuing one 16-bit {addr, wdata} write per start and capturing
// the slave's read-back byte during the second byte. All outputs registered.
module spi_gate_master #(
   parameter int unsigned DIV    = 8,
   parameter int unsigned CS_GAP = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   spi_gate_master_if.master     bus
);

   localparam int unsigned PMAX = (DIV > CS_GAP) ? DIV : CS_GAP;
   localparam int unsigned PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
   localparam int unsigned BW   = 5;

   typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, GAP} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic [BW-1:0]   bit_q,   bit_d;
   logic [15:0]     shift_q, shift_d;
   logic [7:0]      rx_q,    rx_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            csb_q,   csb_d;
   logic            sclk_q,  sclk_d;
   logic            mosi_q,  mosi_d;
   logic            busy_q,  busy_d;
   logic            done_q,  done_d;

   logic            last_div_c;
   logic            last_gap_c;
   logic            rx_bit_c;

   assign last_div_c = (phase_q == PW'(DIV - 1));
   assign last_gap_c = (phase_q == PW'(CS_GAP - 1));
   // Read-back window: MISO is sampled at the end of HIGH 8..15.
   assign rx_bit_c   = (bit_q >= BW'(8)) && (bit_q <= BW'(15));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         phase_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         csb_q   <= 1'b1;
         sclk_q  <= 1'b1;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         csb_q   <= csb_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output logic; outputs are set on state transitions.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      csb_d   = csb_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = SETUP;
               phase_d = '0;
               shift_d = {bus.addr, bus.wdata};
               csb_d   = 1'b0;
               mosi_d  = bus.addr[7];
               busy_d  = 1'b1;
            end
         end

         SETUP: begin
            if (last_div_c) begin
               state_d = LOW;
               phase_d = '0;
               bit_d   = BW'(1);
               sclk_d  = 1'b0;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end

         LOW: begin
            if (last_div_c) begin
               state_d = HIGH;
               phase_d = '0;
               sclk_d  = 1'b1;
               // Frame bit k+1 of the MSB-first word sits at index 15-k.
               mosi_d  = (bit_q == BW'(16)) ? 1'b0 : shift_q[4'(BW'(15) - bit_q)];
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end

         HIGH: begin
            if (last_div_c) begin
               phase_d = '0;
               if (rx_bit_c) begin
                  rx_d[3'(BW'(15) - bit_q)] = bus.MISO;
               end
               if (bit_q == BW'(16)) begin
                  state_d = GAP;
                  csb_d   = 1'b1;
                  mosi_d  = 1'b0;
                  done_d  = 1'b1;
                  rdata_d = rx_q;
               end else begin
                  state_d = LOW;
                  bit_d   = bit_q + BW'(1);
                  sclk_d  = 1'b0;
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end

         GAP: begin
            if (last_gap_c) begin
               state_d = IDLE;
               phase_d = '0;
               busy_d  = 1'b0;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.rdata = rdata_q;
   assign bus.SCLK  = sclk_q;
   assign bus.CSB   = csb_q;
   assign bus.MOSI  = mosi_q;

endmodule

// File: tb/tb_spi_gate_master.sv
// Directed bench for spi_gate_master: three instances (DIV=4, 8, 2) sharing one
// behavioural config slave selected by sel.
module tb_spi_gate_master;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [1:0] sel;
   logic       tie_high;

   int errors = 0;
   int checks = 0;

   spi_gate_master_if ifa ();
   spi_gate_master_if ifb ();
   spi_gate_master_if ifc ();

   spi_gate_master #(.DIV(4), .CS_GAP(4)) u_div4 (.clk(clk), .rst_n(rst_n), .bus(ifa));
   spi_gate_master #(.DIV(8), .CS_GAP(4)) u_div8 (.clk(clk), .rst_n(rst_n), .bus(ifb));
   spi_gate_master #(.DIV(2), .CS_GAP(1)) u_div2 (.clk(clk), .rst_n(rst_n), .bus(ifc));

   always #5 clk = ~clk;

   // Behavioural slave state
   logic        slave_miso = 1'b0;
   logic        miso_line;
   logic [15:0] rx_sh = '0;
   logic [7:0]  tx_sh = '0;
   int          fall_cnt = 0;
   int          cfg_cnt = 0;
   logic [7:0]  cfg_a = '0;
   logic [7:0]  cfg_d = '0;

   assign miso_line = tie_high ? 1'b1 : slave_miso;

   assign ifa.start = start && (sel == 2'd0);
   assign ifb.start = start && (sel == 2'd1);
   assign ifc.start = start && (sel == 2'd2);
   assign ifa.addr  = addr;   assign ifb.addr  = addr;   assign ifc.addr  = addr;
   assign ifa.wdata = wdata;  assign ifb.wdata = wdata;  assign ifc.wdata = wdata;
   assign ifa.MISO  = miso_line;
   assign ifb.MISO  = miso_line;
   assign ifc.MISO  = miso_line;

   logic       sclk_m, csb_m, mosi_m, busy_m, done_m;
   logic [7:0] rdata_m;

   always_comb begin
      case (sel)
         2'd0:    begin sclk_m = ifa.SCLK; csb_m = ifa.CSB; mosi_m = ifa.MOSI;
                        busy_m = ifa.busy; done_m = ifa.done; rdata_m = ifa.rdata; end
         2'd1:    begin sclk_m = ifb.SCLK; csb_m = ifb.CSB; mosi_m = ifb.MOSI;
                        busy_m = ifb.busy; done_m = ifb.done; rdata_m = ifb.rdata; end
         default: begin sclk_m = ifc.SCLK; csb_m = ifc.CSB; mosi_m = ifc.MOSI;
                        busy_m = ifc.busy; done_m = ifc.done; rdata_m = ifc.rdata; end
      endcase
   end

   always @(negedge csb_m) begin
      fall_cnt = 0;
      rx_sh    = '0;
   end

   // Samples MOSI on each fall; returns tx_data for the address from fall 8 on.
   always @(negedge sclk_m) begin
      if (csb_m === 1'b0) begin
         rx_sh    = {rx_sh[14:0], mosi_m};
         fall_cnt = fall_cnt + 1;
         if (fall_cnt == 8)
            tx_sh = (rx_sh[7:0] == 8'h3C) ? 8'hA5 : 8'h5A;
         else if (fall_cnt > 8)
            tx_sh = {tx_sh[6:0], 1'b0};
         slave_miso = tx_sh[7];
      end
   end

   always @(posedge csb_m) begin
      if (fall_cnt == 16) begin
         cfg_cnt = cfg_cnt + 1;
         cfg_a   = rx_sh[15:8];
         cfg_d   = rx_sh[7:0];
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int limit);
      int b = 0;
      while (busy_m && b < limit) begin
         step();
         b++;
      end
      check("idle_timeout", 32'(busy_m), 32'd0);
   endtask

   initial begin
      int n;
      int d;

      rst_n = 1'b0; start = 1'b0; addr = '0; wdata = '0; sel = 2'd0; tie_high = 1'b0;
      repeat (3) step();
      check("rst_csb",   32'(ifa.CSB),   32'd1);
      check("rst_sclk",  32'(ifa.SCLK),  32'd1);
      check("rst_mosi",  32'(ifa.MOSI),  32'd0);
      check("rst_busy",  32'(ifa.busy),  32'd0);
      check("rst_done",  32'(ifa.done),  32'd0);
      check("rst_rdata", 32'(ifa.rdata), 32'd0);
      rst_n = 1'b1;
      repeat (2) step();

      // Write 0x12/0x34 at DIV=4 with a second start pulsed at cycle 40
      addr = 8'h12; wdata = 8'h34; start = 1'b1;
      step();
      start = 1'b0;
      check("acc_csb",  32'(csb_m),  32'd0);
      check("acc_busy", 32'(busy_m), 32'd1);
      n = 0;
      while (csb_m == 1'b0 && n < 1000) begin
         if (n == 39) begin start = 1'b1; addr = 8'hFF; end
         else if (n == 40) begin start = 1'b0; addr = 8'h12; end
         n++;
         step();
      end
      check("wr_csb_low", 32'(n), 32'd132);
      check("wr_done",    32'(done_m), 32'd1);
      check("wr_falls",   32'(fall_cnt), 32'd16);
      check("wr_frame",   32'(rx_sh), 32'h1234);
      check("wr_cfg_cnt", 32'(cfg_cnt), 32'd1);
      step();
      check("wr_done_pulse", 32'(done_m), 32'd0);
      wait_idle(100);
      check("wr_rdata", 32'(rdata_m), 32'h5A);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (csb_m == 1'b0) n++;
         step();
      end
      check("busy_no_second_frame", 32'(n), 32'd0);
      check("busy_cfg_cnt", 32'(cfg_cnt), 32'd1);

      // Back-to-back: start in the cycle busy falls
      addr = 8'h55; wdata = 8'hAA; start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (csb_m == 1'b0 && n < 1000) begin n++; step(); end
      d = 0;
      while (csb_m == 1'b1 && d < 100) begin
         if (busy_m == 1'b0) start = 1'b1;
         step();
         start = 1'b0;
         d++;
      end
      check("b2b_gap", 32'(d), 32'd5);
      wait_idle(1000);
      check("b2b_cfg_cnt", 32'(cfg_cnt), 32'd3);
      check("b2b_cfg_d",   32'(cfg_d),   32'hAA);

      // Read-back at DIV=8
      sel = 2'd1;
      addr = 8'h3C; wdata = 8'h77; start = 1'b1;
      step();
      start = 1'b0;
      step();
      wait_idle(2000);
      check("rb_rdata",   32'(rdata_m), 32'hA5);
      check("rb_cfg_a",   32'(cfg_a),   32'h3C);
      check("rb_cfg_d",   32'(cfg_d),   32'h77);
      check("rb_cfg_cnt", 32'(cfg_cnt), 32'd4);

      // Async reset at fall 9
      addr = 8'h3C; wdata = 8'h80; start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (fall_cnt != 9 && n < 1000) begin n++; step(); end
      check("ar_fall9",   32'(fall_cnt), 32'd9);
      check("ar_pre_mosi", 32'(mosi_m), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_csb",   32'(csb_m),   32'd1);
      check("ar_sclk",  32'(sclk_m),  32'd1);
      check("ar_mosi",  32'(mosi_m),  32'd0);
      check("ar_busy",  32'(busy_m),  32'd0);
      check("ar_rdata", 32'(rdata_m), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("ar_no_cfg", 32'(cfg_cnt), 32'd4);
      addr = 8'h3C; wdata = 8'h11; start = 1'b1;
      step();
      start = 1'b0;
      step();
      wait_idle(2000);
      check("ar_new_rdata", 32'(rdata_m), 32'hA5);
      check("ar_new_cfg_d", 32'(cfg_d),   32'h11);
      check("ar_new_cnt",   32'(cfg_cnt), 32'd5);

      // Minimum DIV=2, MISO tied high
      sel = 2'd2; tie_high = 1'b1;
      addr = 8'hFF; wdata = 8'h00; start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (csb_m == 1'b0 && n < 500) begin n++; step(); end
      check("d2_csb_low", 32'(n), 32'd66);
      check("d2_done",    32'(done_m), 32'd1);
      check("d2_frame",   32'(rx_sh), 32'hFF00);
      wait_idle(100);
      check("d2_rdata",   32'(rdata_m), 32'hFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_gate_master.md
# spi_gate_master

SPI master that issues single 16-bit {address, data} transactions to the board-level SPI config slave (the MAC/IP address setter), emulating the off-chip microcontroller. It drives SCLK, CSB and MOSI, and captures the slave's read-back byte on MISO during the second byte. It is used both in simulation benches and on-chip, wherever one FPGA configures another's local bus over SPI.

## Interface

- DIV, default 8: SCLK half-period in clk cycles; legal range ≥ 2. The SCLK half-period must also exceed the slave's input-sync plus MISO latency, which is ≥ 4 slave clock cycles.
- CS_GAP, default 4: clk cycles CSB is held high after a transaction before busy drops; legal range ≥ 1.
- clk  input  1  sole clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; accepted only when busy=0.
- addr  input  8  address byte, captured at acceptance.
- wdata  input  8  data byte, captured at acceptance.
- busy  output  1  high from the cycle after acceptance through the end of the CS_GAP phase.
- done  output  1  one-cycle pulse when CSB returns high; rdata is valid from that cycle.
- rdata  output  8  byte returned on MISO; holds its value until the next done.
- SCLK  output  1  serial clock; idles high; the slave samples on the falling edge.
- CSB  output  1  chip select, active low.
- MOSI  output  1  serial data, MSB first.
- MISO  input  1  serial data from the slave.

## Operation

- Frame: 16 bits, MSB first, shift word {addr, wdata}. The far end performs a write on every CSB rise, so every transaction is a write. The rdata returned is the slave's tx_data presented for addr.
- FSM states: IDLE, SETUP, LOW, HIGH, GAP. A phase counter runs 0..DIV-1; a bit counter runs 1..16.
- IDLE: CSB=1, SCLK=1, MOSI=0. When start=1, latch {addr, wdata} and go to SETUP.
- SETUP, DIV cycles: CSB=0, MOSI=addr[7]. Then go to LOW with bit=1.
- LOW k, DIV cycles: SCLK=0. Fall k, the entry into LOW k, is where the slave samples bit k. Then go to HIGH k.
- HIGH k, DIV cycles: SCLK=1. On entry, MOSI takes frame bit k+1 for k ≤ 15, and 0 for k = 16.
  - For 8 ≤ k ≤ 15, rdata_shift bit (15-k) samples MISO on the last cycle of HIGH k. The slave loads tx_data[7] after fall 8 and shifts after each later fall.
  - After HIGH k, go to LOW k+1. After HIGH 16, go to GAP.
- GAP, CS_GAP cycles: CSB=1, SCLK=1, MOSI=0. done pulses and rdata updates in the first GAP cycle. busy falls on exit to IDLE.
- start while busy=1 is ignored, with no queueing.
- Reset mid-transaction forces the idle outputs asynchronously. The resulting CSB rise causes a partial write at the far end; this is accepted behaviour.

## Timing

- Reset values: CSB=1, SCLK=1, MOSI=0, busy=0, done=0, rdata=0x00.
- Start accepted at cycle 0. From cycle 1: CSB=0, busy=1.
  - Fall k occurs at cycle 1 + DIV·(2k-1).
  - CSB rises and done pulses at cycle 1 + 33·DIV.
  - busy falls at cycle 1 + 33·DIV + CS_GAP.
  - A new start is accepted in that same cycle, giving a back-to-back period of 1 + 33·DIV + CS_GAP.
- MOSI changes only at SCLK rise or at SETUP entry. It is therefore stable for DIV cycles before and after every falling edge.
- MISO is sampled DIV-1 cycles after the preceding fall, i.e. the last cycle of the high phase.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan

- Write, DIV=4: addr=0x12, wdata=0x34.
  - A bench slave samples MOSI at each SCLK fall and must see 0x1234 over exactly 16 falls.
  - CSB must be low for 132 cycles and done must pulse at cycle 133.
- Read-back, with the spi_gate slave in loop on a 2× faster clock, DIV=8: tx_data=0xA5 for addr 0x3C.
  - rdata must equal 0xA5.
  - The slave must report config_w with config_a=0x3C and config_d=wdata.
- Busy protection: pulse start again at cycle 40 with addr=0xFF. The frame must still carry the original addr, and no second frame may occur until busy=0.
- Back-to-back: assert start in the cycle busy falls, with CS_GAP=4. The second CSB fall must occur exactly 5 cycles after the first CSB rise.
- Async reset at fall 9: CSB=1, SCLK=1 and MOSI=0 must hold immediately, with no clk edge needed. busy=0 and rdata=0x00. A new start after reset produces a clean frame.
- Minimum DIV=2: the frame 0xFF00 with MISO tied high must give rdata=0xFF. Total CSB-low time must be 66 cycles.
